adc_frame_sequencer: RTL and testbench
======================================

Name: adc_frame_sequencer

Overview:
- Controller for the dual-channel 12-bit serial ADC front end.
- Generates the ADC chip-select and the serial clock from the system clock.
- Shifts in one 16-bit frame per conversion on two data lines that share CS and SCLK. Each frame is 4 leading zeros followed by 12 data bits, MSB first.
- Schedules conversions as single-shot, on request, or continuously at a fixed rate, and presents both channel results with a one-cycle valid strobe to downstream logic.

Parameters:
- CLK_DIV, 4: system-clock cycles per serial-clock half-period; must be >= 2.
- QUIET_CYCLES, 8: system-clock cycles CS is held high between frames; must be >= 1.
- DATA_W, 12: result width; frame length is fixed at 16 bits, so the lead-zero count is 16 - DATA_W.

Ports:
- sclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  continuous-conversion request, level-sensitive.
- start  in  1  single-shot request, sampled each cycle.
- adc_d0  in  1  ADC channel 0 serial data.
- adc_d1  in  1  ADC channel 1 serial data.
- adc_cs_n  out  1  ADC chip select, active low; registered.
- adc_clk  out  1  ADC serial clock, idles high; registered.
- data0  out  DATA_W  last channel 0 result.
- data1  out  DATA_W  last channel 1 result.
- valid  out  1  one-cycle strobe when data0/data1 update.
- busy  out  1  high whenever state is not IDLE.
- frame_err  out  1  lead bits nonzero in the last frame on either channel.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state=IDLE, adc_cs_n=1, adc_clk=1, data0=data1=0, valid=0, frame_err=0, pending=0.
  - Divider, bit counter and shift registers cleared.
- States: IDLE, SETUP, SHIFT, DONE, QUIET.
- IDLE:
  - adc_cs_n=1, adc_clk=1.
  - Enter SETUP when start=1 or enable=1; adc_cs_n=0 from that edge.
- SETUP:
  - adc_cs_n=0, adc_clk=1 for CLK_DIV cycles, then SHIFT.
- SHIFT:
  - Divider counts 0..CLK_DIV-1; adc_clk toggles when the divider wraps. First toggle is 1->0.
  - On each registered 0->1 toggle, adc_d0/adc_d1 are shifted MSB-first into 16-bit shift registers.
  - After the 16th rising toggle (32 half-periods, 32*CLK_DIV cycles), adc_clk ends high and the block goes to DONE.
- DONE (entered on that same edge):
  - data0/data1 <= low DATA_W bits of the shift registers.
  - frame_err <= OR of the lead bits of both channels.
  - valid=1 for exactly one cycle; adc_cs_n=1.
  - Then QUIET.
- QUIET:
  - adc_cs_n=1 for QUIET_CYCLES cycles.
  - Then SETUP if enable=1 or pending=1 (pending cleared on that edge); otherwise IDLE.
- Latency: start sampled at edge N gives valid high in the cycle after edge N+CLK_DIV*33. Default: N+132.
- Continuous period: CLK_DIV*33+1+QUIET_CYCLES cycles. Default: 141.
- pending:
  - start=1 outside IDLE sets pending.
  - Repeated starts collapse to one pending request.
  - start in IDLE does not set pending.
- enable or start deasserting mid-frame: the frame always completes; outputs update normally.
- start and enable both high in IDLE: one SETUP entry; start is consumed.
- data0, data1 and frame_err hold their values between DONE states.

Test Plan:
1. Single shot: start pulse at edge N, adc_d0 drives 0x0ABC, adc_d1 drives 0x0123 (bits changed after falling adc_clk) -> adc_cs_n low edges N..N+132; data0=0xABC, data1=0x123; valid high one cycle after edge N+132; frame_err=0; back to IDLE, busy=0 at N+141.
2. Continuous: enable held high, frames 0x0555/0x0AAA -> valid pulses exactly 141 cycles apart; adc_cs_n high 9 cycles between frames; 16 rising adc_clk edges per frame.
3. Lead error: adc_d0 frame 0x8001, adc_d1 0x0FFF -> data0=0x001, data1=0xFFF, frame_err=1. Next clean frame clears frame_err to 0.
4. Pending start: start pulsed twice during SHIFT, enable=0 -> exactly one additional frame begins after QUIET; then IDLE.
5. Reset mid-SHIFT after 7 bits -> immediately adc_cs_n=1, adc_clk=1, data0=data1=0, valid=0. A following start yields a correct full frame.
6. enable dropped mid-SHIFT -> current frame completes with valid; no further frame; IDLE after QUIET.

Source files
------------

// File: rtl/adc_frame_sequencer.sv
// Sequencer for the dual-channel 12-bit serial ADC: generates CS and the serial
// clock, shifts in one 16-bit frame per conversion on both data lines, and strobes results.
module adc_frame_sequencer #(
   parameter int CLK_DIV      = 4,
   parameter int QUIET_CYCLES = 8,
   parameter int DATA_W       = 12
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              enable,
   input  logic              start,
   input  logic              adc_d0,
   input  logic              adc_d1,
   output logic              adc_cs_n,
   output logic              adc_clk,
   output logic [DATA_W-1:0] data0,
   output logic [DATA_W-1:0] data1,
   output logic              valid,
   output logic              busy,
   output logic              frame_err
);

   // state | meaning
   // IDLE  | CS high, waiting for start or enable
   // SETUP | CS low, serial clock held high for CLK_DIV cycles
   // SHIFT | 32 serial-clock half-periods, one bit captured per rising toggle
   // DONE  | results registered, valid strobe, CS released
   // QUIET | CS held high for QUIET_CYCLES before the next frame or IDLE

   localparam int FRAME_W = 16;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TMR_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] QUIET_LOAD = TMR_W'(QUIET_CYCLES - 1);
   localparam logic [4:0]       HALF_LOAD  = 5'd31;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      DONE  = 3'd3,
      QUIET = 3'd4
   } state_t;

   state_t             state;
   logic [DIV_W-1:0]   div;
   logic [TMR_W-1:0]   tmr;
   logic [4:0]         half_cnt;
   logic [FRAME_W-2:0] sh0;
   logic [FRAME_W-2:0] sh1;
   logic               pending;

   logic [FRAME_W-1:0] nxt0;
   logic [FRAME_W-1:0] nxt1;
   logic               div_wrap;
   logic               lead_err;
   logic               go_again;

   // The 16th bit lands on the same edge as DONE, so results use the
   // shift register contents plus the bit being sampled now.
   assign nxt0     = {sh0, adc_d0};
   assign nxt1     = {sh1, adc_d1};
   assign div_wrap = (div == DIV_LAST);
   assign lead_err = (|nxt0[FRAME_W-1:DATA_W]) | (|nxt1[FRAME_W-1:DATA_W]);
   assign go_again = enable | pending | start;
   assign busy     = (state != IDLE);

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         adc_cs_n  <= 1'b1;
         adc_clk   <= 1'b1;
         data0     <= '0;
         data1     <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         pending   <= 1'b0;
         div       <= '0;
         tmr       <= '0;
         half_cnt  <= '0;
         sh0       <= '0;
         sh1       <= '0;
      end else begin
         valid <= 1'b0;
         if (start && (state != IDLE))
            pending <= 1'b1;

         case (state)
            IDLE: begin
               adc_cs_n <= 1'b1;
               adc_clk  <= 1'b1;
               if (start || enable) begin
                  state    <= SETUP;
                  adc_cs_n <= 1'b0;
                  tmr      <= SETUP_LOAD;
                  pending  <= 1'b0;
               end
            end

            SETUP: begin
               adc_clk <= 1'b1;
               if (tmr == '0) begin
                  state    <= SHIFT;
                  div      <= '0;
                  half_cnt <= HALF_LOAD;
                  sh0      <= '0;
                  sh1      <= '0;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end

            SHIFT: begin
               if (div_wrap) begin
                  div     <= '0;
                  adc_clk <= ~adc_clk;
                  if (!adc_clk) begin
                     sh0 <= nxt0[FRAME_W-2:0];
                     sh1 <= nxt1[FRAME_W-2:0];
                  end
                  if (half_cnt == '0) begin
                     state     <= DONE;
                     adc_cs_n  <= 1'b1;
                     valid     <= 1'b1;
                     data0     <= nxt0[DATA_W-1:0];
                     data1     <= nxt1[DATA_W-1:0];
                     frame_err <= lead_err;
                  end else begin
                     half_cnt <= half_cnt - 1'b1;
                  end
               end else begin
                  div <= div + 1'b1;
               end
            end

            DONE: begin
               state <= QUIET;
               tmr   <= QUIET_LOAD;
            end

            QUIET: begin
               adc_cs_n <= 1'b1;
               adc_clk  <= 1'b1;
               if (tmr == '0) begin
                  // A start landing on this very edge is taken as a new
                  // request rather than left stranded as a stale pending.
                  pending <= 1'b0;
                  if (go_again) begin
                     state    <= SETUP;
                     adc_cs_n <= 1'b0;
                     tmr      <= SETUP_LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               adc_cs_n <= 1'b1;
               adc_clk  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed bench for adc_frame_sequencer with a behavioural two-channel ADC
// that shifts a new frame bit out after every falling serial clock.
module tb_adc_frame_sequencer;

   logic        sclk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        start = 1'b0;
   logic        adc_d0 = 1'b0;
   logic        adc_d1 = 1'b0;
   logic        adc_cs_n;
   logic        adc_clk;
   logic [11:0] data0;
   logic [11:0] data1;
   logic        valid;
   logic        busy;
   logic        frame_err;

   adc_frame_sequencer #(.CLK_DIV(4), .QUIET_CYCLES(8), .DATA_W(12)) dut (
      .sclk      (sclk),
      .rst       (rst),
      .enable    (enable),
      .start     (start),
      .adc_d0    (adc_d0),
      .adc_d1    (adc_d1),
      .adc_cs_n  (adc_cs_n),
      .adc_clk   (adc_clk),
      .data0     (data0),
      .data1     (data1),
      .valid     (valid),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 sclk = ~sclk;

   int n_tests = 0;
   int n_fail  = 0;

   int cyc = 0;
   always @(posedge sclk) cyc++;

   logic [15:0] f0 = 16'h0000;
   logic [15:0] f1 = 16'h0000;
   int bit_idx = 15;
   logic prev_clk = 1'b1;
   logic prev_cs  = 1'b1;
   int n_valid = 0, last_vcyc = 0, prev_vcyc = 0, n_frames = 0;
   int cs_low = 0, rises = 0, rises_at_valid = 0, hi_run = 0, last_gap = 0;

   // ADC model and activity monitor share one block so the model sees the
   // previous adc_clk level before it is updated.
   always @(negedge sclk) begin
      if (adc_cs_n) bit_idx = 15;
      else if (prev_clk && !adc_clk && bit_idx >= 0) begin
         adc_d0 = f0[bit_idx];
         adc_d1 = f1[bit_idx];
         bit_idx--;
      end
      if (!prev_clk && adc_clk) rises++;
      if (prev_cs && !adc_cs_n) begin
         n_frames++;
         rises = 0;
         if (hi_run > 0) last_gap = hi_run;
      end
      if (!busy || !adc_cs_n) hi_run = 0;
      else hi_run++;
      if (!adc_cs_n) cs_low++;
      if (valid) begin
         n_valid++;
         prev_vcyc = last_vcyc;
         last_vcyc = cyc;
         rises_at_valid = rises;
      end
      prev_clk = adc_clk;
      prev_cs  = adc_cs_n;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge sclk);
   endtask

   task automatic do_start(output int n);
      @(negedge sclk);
      start = 1'b1;
      @(posedge sclk);
      #1;
      n = cyc;
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int n0, n1, bv, bf, bl;

   initial begin
      #2 rst = 1'b1;
      #3;
      check_val("rst_cs_n", adc_cs_n, 1);
      check_val("rst_adc_clk", adc_clk, 1);
      check_val("rst_valid", valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_data0", data0, 0);
      check_val("rst_frame_err", frame_err, 0);
      repeat (3) @(negedge sclk);
      rst = 1'b0;
      repeat (3) @(negedge sclk);

      // single shot
      f0 = 16'h0ABC; f1 = 16'h0123;
      bv = n_valid; bl = cs_low;
      do_start(n0);
      check_val("t1_cs_low_at_n", adc_cs_n, 0);
      wait_to(n0 + 131);
      check_val("t1_no_early_valid", n_valid - bv, 0);
      wait_to(n0 + 140);
      check_val("t1_latency", last_vcyc - n0, 132);
      check_val("t1_valid_once", n_valid - bv, 1);
      check_val("t1_cs_low_cycles", cs_low - bl, 132);
      check_val("t1_rises", rises_at_valid, 16);
      check_val("t1_data0", data0, 12'hABC);
      check_val("t1_data1", data1, 12'h123);
      check_val("t1_frame_err", frame_err, 0);
      check_val("t1_busy_quiet", busy, 1);
      wait_to(n0 + 141);
      check_val("t1_busy_idle", busy, 0);

      // continuous, enable dropped mid-SHIFT of the third frame
      f0 = 16'h0555; f1 = 16'h0AAA;
      bv = n_valid; bf = n_frames;
      @(negedge sclk);
      enable = 1'b1;
      @(posedge sclk);
      #1 n0 = cyc;
      wait_to(n0 + 300);
      check_val("t2_valid_count", n_valid - bv, 2);
      check_val("t2_period", last_vcyc - prev_vcyc, 141);
      check_val("t2_first_latency", prev_vcyc - n0, 132);
      check_val("t2_cs_gap", last_gap, 9);
      check_val("t2_rises", rises_at_valid, 16);
      check_val("t2_data0", data0, 12'h555);
      check_val("t2_data1", data1, 12'hAAA);
      wait_to(n0 + 332);
      enable = 1'b0;
      wait_to(n0 + 422);
      check_val("t6_busy_quiet", busy, 1);
      check_val("t6_last_valid", last_vcyc - n0, 414);
      wait_to(n0 + 423);
      check_val("t6_busy_idle", busy, 0);
      wait_to(n0 + 460);
      check_val("t6_valid_count", n_valid - bv, 3);
      check_val("t6_frames", n_frames - bf, 3);
      check_val("t6_cs_idle", adc_cs_n, 1);

      // lead-bit error, then a clean frame clears it
      f0 = 16'h8001; f1 = 16'h0FFF;
      do_start(n0);
      wait_to(n0 + 141);
      check_val("t3_data0", data0, 12'h001);
      check_val("t3_data1", data1, 12'hFFF);
      check_val("t3_frame_err", frame_err, 1);
      wait_to(n0 + 150);
      check_val("t3_err_hold", frame_err, 1);
      f0 = 16'h0ABC; f1 = 16'h0123;
      do_start(n1);
      wait_to(n1 + 141);
      check_val("t3_err_clear", frame_err, 0);
      check_val("t3_clean_data0", data0, 12'hABC);

      // two starts during SHIFT collapse to one extra frame
      f0 = 16'h0F0F; f1 = 16'h00F0;
      bv = n_valid; bf = n_frames;
      do_start(n0);
      wait_to(n0 + 20);
      start = 1'b1;
      @(posedge sclk);
      #1 start = 1'b0;
      wait_to(n0 + 60);
      start = 1'b1;
      @(posedge sclk);
      #1 start = 1'b0;
      wait_to(n0 + 281);
      check_val("t4_busy_before", busy, 1);
      wait_to(n0 + 282);
      check_val("t4_busy_idle", busy, 0);
      check_val("t4_valid_count", n_valid - bv, 2);
      check_val("t4_period", last_vcyc - prev_vcyc, 141);
      wait_to(n0 + 320);
      check_val("t4_frames", n_frames - bf, 2);
      check_val("t4_data0", data0, 12'hF0F);

      // reset mid-SHIFT after seven bits
      f0 = 16'h0321; f1 = 16'h0456;
      do_start(n0);
      wait_to(n0 + 62);
      check_val("t5_rises_before_rst", rises, 7);
      #2 rst = 1'b1;
      #1;
      check_val("t5_cs_n", adc_cs_n, 1);
      check_val("t5_adc_clk", adc_clk, 1);
      check_val("t5_data0", data0, 0);
      check_val("t5_data1", data1, 0);
      check_val("t5_valid", valid, 0);
      check_val("t5_busy", busy, 0);
      repeat (2) @(negedge sclk);
      rst = 1'b0;
      bv = n_valid;
      do_start(n0);
      wait_to(n0 + 141);
      check_val("t5_after_data0", data0, 12'h321);
      check_val("t5_after_data1", data1, 12'h456);
      check_val("t5_after_valid", n_valid - bv, 1);
      check_val("t5_after_err", frame_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
